dmem_responder: RTL

- Data-memory responder for the core's load/store port; the other end of the core's request interface.
- Accepts `i_loadReq`/`i_storeReq`/`i_dataAddr`/`i_dataOut` from the core's MEM stage and returns `o_dataIn`/`o_memValid`.
- Stores are posted into an in-order store buffer, because the core never stalls on stores. Loads stall until the buffer drains, then issue one read.
- Drives a generic request/grant RAM port (single-port SRAM, BRAM wrapper or bus bridge).

---
 rtl/dmem_responder.sv | 81 ++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: core load/store responder with a posted in-order store buffer
// driving a request/grant RAM port; loads wait for the buffer to drain.
module dmem_responder #(
   parameter int XLEN     = 32,
   parameter int SB_DEPTH = 4
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_loadReq,
   input  logic            i_storeReq,
   input  logic [XLEN-1:0] i_dataAddr,
   input  logic [XLEN-1:0] i_dataOut,
   output logic [XLEN-1:0] o_dataIn,
   output logic            o_memValid,
   output logic            o_ramReq,
   output logic            o_ramWe,
   output logic [XLEN-1:0] o_ramAddr,
   output logic [XLEN-1:0] o_ramWdata,
   input  logic            i_ramGnt,
   input  logic            i_ramRvalid,
   input  logic [XLEN-1:0] i_ramRdata,
   output logic            o_sbEmpty,
   output logic            o_overflow
);
   localparam int SB_AW = $clog2(SB_DEPTH);
   localparam logic [SB_AW:0] SB_FULL = (SB_AW+1)'(SB_DEPTH);
   typedef enum logic [2:0] {IDLE, LD_WAIT_SB, LD_REQ, LD_DATA, RESP} state_t;
   state_t state;
   logic [XLEN-1:0] sb_addr [SB_DEPTH];
   logic [XLEN-1:0] sb_data [SB_DEPTH];
   logic [SB_AW-1:0] wr_ptr, rd_ptr;
   logic [SB_AW:0] count;
   logic [XLEN-1:0] ld_addr, aligned;
   logic drain, pop, push_ok;
   assign aligned = i_dataAddr & ~XLEN'(3);
   // write drain owns the port whenever no read is in flight
   assign drain = (count != '0) && (state == IDLE || state == LD_WAIT_SB);
   assign pop = drain && i_ramGnt;
   assign push_ok = i_storeReq && (count != SB_FULL || pop);
   assign o_ramReq = drain || state == LD_REQ;
   assign o_ramWe = drain;
   assign o_ramAddr = drain ? sb_addr[rd_ptr] : ld_addr;
   assign o_ramWdata = sb_data[rd_ptr];
   assign o_sbEmpty = count == '0;
   assign o_memValid = state == RESP;
   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         sb_addr[wr_ptr] <= aligned;
         sb_data[wr_ptr] <= i_dataOut;
      end
   end
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         ld_addr    <= '0;
         o_dataIn   <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (SB_AW+1)'(push_ok) - (SB_AW+1)'(pop);
         if (i_storeReq && !push_ok) o_overflow <= 1'b1;
         case (state)
            IDLE: if (i_loadReq) begin
               ld_addr <= aligned;
               state   <= (o_sbEmpty && !i_storeReq) ? LD_REQ : LD_WAIT_SB;
            end
            LD_WAIT_SB: if (o_sbEmpty) state <= LD_REQ;
            LD_REQ: if (i_ramGnt) state <= LD_DATA;
            LD_DATA: if (i_ramRvalid) begin
               o_dataIn <= i_ramRdata;
               state    <= RESP;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
